// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM answering Req with a Pronto pulse after a
// configurable read/write latency; misaligned requests are rejected in one cycle.
module mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int READ_LAT    = 2,
    parameter int WRITE_LAT   = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req,
    input  logic              CtrMem,
    input  logic [ADDR_W-1:0] Endereco,
    input  logic [DATA_W-1:0] DadoEsc,
    output logic [DATA_W-1:0] DadoLido,
    output logic              Pronto,
    output logic              Ocupado,
    output logic              ErroAlinh,
    output logic [1:0]        state
);
    localparam int IW   = $clog2(DEPTH_WORDS);
    localparam int MAXL = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, RESP = 2'b10} state_t;

    state_t            cur, nxt;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic              wr_q;
    logic [IW-1:0]     idx_q;
    logic [DATA_W-1:0] data_q;
    logic [CW-1:0]     cnt;
    logic              accept, mis, done;
    logic              unused;

    // Address bits above the RAM index are deliberately ignored (wrap-around).
    assign unused  = ^Endereco[ADDR_W-1:IW+2];
    assign accept  = (cur == IDLE) && Req;
    assign mis     = Endereco[1:0] != 2'b00;
    assign done    = (cur == WAIT) && (cnt == '0);
    assign state   = cur;
    assign Pronto  = cur == RESP;
    assign Ocupado = cur != IDLE;

    always_comb begin
        nxt = IDLE;
        if (cur == IDLE)
            nxt = Req ? (mis ? RESP : WAIT) : IDLE;
        else if (cur == WAIT)
            nxt = (cnt == '0) ? RESP : WAIT;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cur       <= IDLE;
            cnt       <= '0;
            DadoLido  <= '0;
            ErroAlinh <= 1'b0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            data_q    <= '0;
        end else begin
            cur       <= nxt;
            ErroAlinh <= accept && mis;
            if (accept) begin
                wr_q   <= CtrMem;
                idx_q  <= Endereco[IW+1:2];
                data_q <= DadoEsc;
                cnt    <= CtrMem ? CW'(WRITE_LAT - 1) : CW'(READ_LAT - 1);
            end else if (cur == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (done && !wr_q)
                DadoLido <= mem[idx_q];
        end
    end

    // An async reset forces IDLE, so a write whose final WAIT edge is cut off never lands.
    always_ff @(posedge Clock) begin
        if (done && wr_q)
            mem[idx_q] <= data_q;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a
// word-array model of the RAM and the documented latency rules.
module tb_mem_responder;
    logic        Clock = 0, Reset = 0, Req = 0, CtrMem = 0;
    logic [31:0] Endereco = 0, DadoEsc = 0;
    logic [31:0] DadoLido;
    logic        Pronto, Ocupado, ErroAlinh;
    logic [1:0]  state;

    int          total = 0, bad = 0;
    logic [31:0] mm [256];
    logic [31:0] last_rd = 0;

    mem_responder dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .CtrMem(CtrMem),
        .Endereco(Endereco), .DadoEsc(DadoEsc), .DadoLido(DadoLido),
        .Pronto(Pronto), .Ocupado(Ocupado), .ErroAlinh(ErroAlinh), .state(state)
    );

    always #5 Clock = ~Clock;

    // Issues one request from IDLE; lat counts edges after the accept edge until Pronto.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic err, output logic [31:0] rd,
                          output logic pulse2);
        int g = 0;
        while (Ocupado && g < 20) begin @(posedge Clock); #1; g++; end
        Req = 1; CtrMem = wr; Endereco = a; DadoEsc = d;
        @(posedge Clock); #1;
        Req = 0; CtrMem = 1'($urandom); Endereco = $urandom; DadoEsc = $urandom;
        lat = 0;
        while (!Pronto && lat < 20) begin @(posedge Clock); #1; lat++; end
        err = ErroAlinh; rd = DadoLido;
        @(posedge Clock); #1;
        pulse2 = Pronto;
    endtask

    task automatic test_reset;
        #1 Reset = 1;
        #7;
        total++;
        if ({DadoLido, Pronto, Ocupado, ErroAlinh, state} !== 37'd0) begin
            bad++;
            $display("FAIL reset_state: got %h,%b%b%b,%b want 0", DadoLido, Pronto, Ocupado, ErroAlinh, state);
        end
        #5 Reset = 0;
        @(posedge Clock); #1;
    endtask

    task automatic prefill;
        int l; logic e, p; logic [31:0] r, d;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            do_req(1, i * 4, d, l, e, r, p);
            mm[i] = d;
        end
    endtask

    task automatic test_write_read;
        int l; logic e, p; logic [31:0] r;
        do_req(1, 32'h10, 32'hDEADBEEF, l, e, r, p);
        mm[4] = 32'hDEADBEEF;
        total++;
        if (l !== 1 || e !== 0) begin bad++; $display("FAIL wr_lat: lat=%0d err=%b want 1,0", l, e); end
        do_req(0, 32'h10, 32'h0, l, e, r, p);
        last_rd = mm[4];
        total++;
        if (l !== 2 || r !== 32'hDEADBEEF || p !== 0) begin
            bad++; $display("FAIL rd_lat: lat=%0d data=%h p2=%b want 2,deadbeef,0", l, r, p);
        end
    endtask

    task automatic test_misalign;
        int l; logic e, p; logic [31:0] r;
        do_req(0, 32'h13, 32'h0, l, e, r, p);
        total++;
        if (l !== 0 || e !== 1 || r !== last_rd || p !== 0) begin
            bad++; $display("FAIL misalign: lat=%0d err=%b data=%h p2=%b want 0,1,%h,0", l, e, r, p, last_rd);
        end
        do_req(0, 32'h10, 32'h0, l, e, r, p);
        total++;
        if (r !== 32'hDEADBEEF || e !== 0) begin
            bad++; $display("FAIL misalign_after: data=%h err=%b want deadbeef,0", r, e);
        end
    endtask

    task automatic test_hold;
        logic ep, eo;
        Req = 1; CtrMem = 0; Endereco = 32'h10;
        for (int k = 1; k <= 12; k++) begin
            @(posedge Clock); #1;
            ep = (k % 4) == 3;
            eo = (k % 4) != 0;
            total++;
            if (Pronto !== ep || Ocupado !== eo || (ep && DadoLido !== 32'hDEADBEEF)) begin
                bad++;
                $display("FAIL hold_k%0d: pronto=%b ocupado=%b data=%h want %b,%b,deadbeef", k, Pronto, Ocupado, DadoLido, ep, eo);
            end
        end
        Req = 0;
        @(posedge Clock); #1;
    endtask

    task automatic test_reset_wait;
        Req = 1; CtrMem = 0; Endereco = 32'h10;
        @(posedge Clock); #1;
        Req = 0;
        #2 Reset = 1;
        #1;
        total++;
        if ({DadoLido, Pronto, Ocupado, ErroAlinh, state} !== 37'd0) begin
            bad++;
            $display("FAIL reset_wait: got %h,%b%b%b,%b want 0", DadoLido, Pronto, Ocupado, ErroAlinh, state);
        end
        #2 Reset = 0;
        last_rd = 0;
        @(posedge Clock); #1;
    endtask

    task automatic test_wrap;
        int l; logic e, p; logic [31:0] r;
        do_req(1, 32'd1032, 32'hA5, l, e, r, p);
        mm[2] = 32'hA5;
        do_req(0, 32'h8, 32'h0, l, e, r, p);
        last_rd = mm[2];
        total++;
        if (r !== 32'hA5 || l !== 2) begin bad++; $display("FAIL wrap: data=%h lat=%0d want a5,2", r, l); end
    endtask

    task automatic test_abort;
        int l; logic e, p; logic [31:0] r; int np = 0;
        do_req(1, 32'h20, 32'h0, l, e, r, p);
        mm[8] = 0;
        Req = 1; CtrMem = 1; Endereco = 32'h20; DadoEsc = 32'h12345678;
        @(posedge Clock); #1;
        Req = 0;
        #2 Reset = 1;
        #2 Reset = 0;
        for (int k = 0; k < 4; k++) begin @(posedge Clock); #1; if (Pronto) np++; end
        last_rd = 0;
        total++;
        if (np !== 0) begin bad++; $display("FAIL abort_pronto: pulses=%0d want 0", np); end
        do_req(0, 32'h20, 32'h0, l, e, r, p);
        last_rd = mm[8];
        total++;
        if (r !== 32'h0 || l !== 2) begin bad++; $display("FAIL abort_data: data=%h lat=%0d want 0,2", r, l); end
    endtask

    task automatic test_random;
        int l, el; logic e, p, wr, em; logic [31:0] r, a, d; logic [7:0] idx;
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d = $urandom;
            em = a[1:0] != 2'b00;
            idx = a[9:2];
            el = em ? 0 : (wr ? 1 : 2);
            do_req(wr, a, d, l, e, r, p);
            if (!em && wr) mm[idx] = d;
            if (!em && !wr) last_rd = mm[idx];
            total++;
            if (l !== el || e !== em || r !== last_rd || p !== 0) begin
                bad++;
                $display("FAIL rand_%0d: lat=%0d err=%b data=%h p2=%b want %0d,%b,%h,0", n, l, e, r, p, el, em, last_rd);
            end
        end
    endtask

    initial begin
        test_reset;
        prefill;
        test_write_read;
        test_misalign;
        test_hold;
        test_reset_wait;
        test_wrap;
        test_abort;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
